// File: rtl/alu_multdiv_if.sv
// alu_multdiv_if: operand/opcode/result bus between the execute stage and
// the multi-cycle multiply/divide unit.
//   data_operandA/B : operands, only meaningful on a start cycle
//   ctrl_MULT/DIV   : single-cycle start pulses (MULT has priority)
//   data_result     : product low word or quotient, held until next completion
//   data_exception  : error flag for the last completed op
//   data_resultRDY  : one-cycle completion pulse
//   busy            : operation in flight
// master = processor side, slave = multiply/divide unit.
interface alu_multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/alu_multdiv.sv
// alu_multdiv: multi-cycle signed multiply / divide unit.
// Multiply is radix-2 shift-add over operand magnitudes; divide is restoring
// division over magnitudes. Sign is applied when the result is registered.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : alu_multdiv_if.slave (operands, start pulses, result, flags)
// Timing: start sampled at edge k, 32 iterations at edges k+1..k+32, result
// and data_resultRDY appear after edge k+33. A new start in any state aborts
// the current op (no RDY for it) and restarts with the new operands.
module alu_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    alu_multdiv_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    // MUL: {partial product high, multiplier shifting out / product low}
    // DIV: {remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic               neg_q;
    logic               dz_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;

    logic start_mul, start_div, start;
    logic load, step, finish;
    logic last;

    assign start_mul = bus.ctrl_MULT;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign start     = start_mul | start_div;
    assign last      = (cnt_q == CNT_W'(WIDTH));

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        if (start) begin
            // Start wins in every state, including the last iteration.
            load    = 1'b1;
            state_d = start_mul ? MUL : DIV;
        end else begin
            case (state_q)
                MUL, DIV: begin
                    if (last) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- operand magnitudes ----------------
    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // ---------------- multiply step ----------------
    // One extra bit on the high half keeps the add carry before the shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // ---------------- divide step ----------------
    // Shift remainder left, pulling in the next dividend bit; subtract if it fits.
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_sh >= {1'b0, mag_b_q});
    assign div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, mag_b_q}) : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // ---------------- finalize ----------------
    logic [2*WIDTH-1:0] prod;
    logic               mul_exc;
    logic [WIDTH-1:0]   quo;
    logic               div_exc;
    assign prod    = neg_q ? -acc_q : acc_q;
    assign mul_exc = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    assign quo     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // A positive quotient with the top bit set can only come from MIN / -1.
    assign div_exc = dz_q | (~neg_q & acc_q[WIDTH-1]);

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (load) begin
            cnt_q   <= '0;
            mag_a_q <= abs_a;
            mag_b_q <= abs_b;
            neg_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            dz_q    <= (bus.data_operandB == '0);
            acc_q   <= start_mul ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
        end else if (step) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= (state_q == MUL) ? mul_next : div_next;
        end else if (finish) begin
            if (state_q == MUL) begin
                result_q <= prod[WIDTH-1:0];
                exc_q    <= mul_exc;
            end else begin
                result_q <= div_exc ? '0 : quo;
                exc_q    <= div_exc;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.busy           = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_alu_multdiv.sv
// Directed bench for alu_multdiv: hand-computed vectors, latency, restart,
// start-in-DONE, and mid-op reset.
module tb_alu_multdiv;

    logic clock;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    alu_multdiv_if #(.WIDTH(32)) bus ();

    alu_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges, landing on the following negedge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Called at a negedge; the start is sampled at the next posedge, then
    // operands are scrambled to show they are not re-read.
    task automatic do_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Called at the negedge after the start edge k. Edges k+1..k+32: no RDY,
    // busy high, result held. Edge k+33: RDY with expected result.
    task automatic expect_done(input string tag, input logic [31:0] res, input logic exc);
        bit          early    = 1'b0;
        bit          not_busy = 1'b0;
        bit          changed  = 1'b0;
        logic [31:0] held;
        held = bus.data_result;
        for (int i = 1; i < 33; i++) begin
            step(1);
            if (bus.data_resultRDY !== 1'b0) early    = 1'b1;
            if (bus.busy !== 1'b1)           not_busy = 1'b1;
            if (bus.data_result !== held)    changed  = 1'b1;
        end
        chk({tag, "_no_early_rdy"}, 64'(early), 64'(0));
        chk({tag, "_busy"}, 64'(not_busy), 64'(0));
        chk({tag, "_held"}, 64'(changed), 64'(0));
        step(1);
        chk({tag, "_rdy"}, 64'(bus.data_resultRDY), 64'(1));
        chk({tag, "_busy_low"}, 64'(bus.busy), 64'(0));
        chk({tag, "_result"}, 64'(bus.data_result), 64'(res));
        chk({tag, "_exc"}, 64'(bus.data_exception), 64'(exc));
    endtask

    initial begin
        bit seen;
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        step(2);
        reset_n = 1'b1;
        chk("reset_result", 64'(bus.data_result), 64'(0));
        chk("reset_exc", 64'(bus.data_exception), 64'(0));
        chk("reset_rdy", 64'(bus.data_resultRDY), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));
        step(2);

        // Multiply basic, then a start sampled in DONE (RDY cycle).
        do_start(1, 0, 32'd7, 32'd6);
        chk("mul7x6_busy_start", 64'(bus.busy), 64'(1));
        expect_done("mul7x6", 32'h0000002A, 1'b0);
        do_start(1, 0, 32'hFFFFFFFD, 32'd5);
        chk("rdy_one_cycle", 64'(bus.data_resultRDY), 64'(0));
        chk("done_restart_busy", 64'(bus.busy), 64'(1));
        expect_done("mul_m3x5", 32'hFFFFFFF1, 1'b0);
        step(1);
        chk("rdy_drop", 64'(bus.data_resultRDY), 64'(0));

        do_start(1, 0, 32'h00010000, 32'h00010000);
        expect_done("mul_ovf", 32'h00000000, 1'b1);
        step(1);
        do_start(1, 0, 32'hFFFF0000, 32'h00008000);
        expect_done("mul_min", 32'h80000000, 1'b0);
        step(1);
        do_start(1, 0, 32'd0, 32'hDEADBEEF);
        expect_done("mul_zero", 32'h00000000, 1'b0);
        step(1);

        // Divide
        do_start(0, 1, 32'd100, 32'd7);
        expect_done("div100_7", 32'h0000000E, 1'b0);
        step(1);
        do_start(0, 1, 32'hFFFFFF9C, 32'd7);
        expect_done("div_m100_7", 32'hFFFFFFF2, 1'b0);
        step(1);
        do_start(0, 1, 32'd7, 32'd100);
        expect_done("div7_100", 32'h00000000, 1'b0);
        step(1);
        do_start(0, 1, 32'd5, 32'd0);
        expect_done("div_by0", 32'h00000000, 1'b1);
        step(1);
        do_start(0, 1, 32'h80000000, 32'hFFFFFFFF);
        expect_done("div_ovf", 32'h00000000, 1'b1);
        step(1);

        // Restart: MULT at edge k, DIV at edge k+10 -> single RDY at k+43.
        do_start(1, 0, 32'd3, 32'd4);
        step(9);
        do_start(0, 1, 32'd9, 32'd3);
        expect_done("restart", 32'h00000003, 1'b0);
        step(1);

        // Both starts high: multiply wins.
        do_start(1, 1, 32'd6, 32'd3);
        expect_done("both", 32'h00000012, 1'b0);
        step(1);

        // Reset at edge k+15 of a multiply.
        do_start(1, 0, 32'd7, 32'd6);
        step(14);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("midrst_result", 64'(bus.data_result), 64'(0));
        chk("midrst_exc", 64'(bus.data_exception), 64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_rdy", 64'(bus.data_resultRDY), 64'(0));
        seen = 1'b0;
        for (int i = 16; i <= 60; i++) begin
            step(1);
            if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        chk("midrst_quiet", 64'(seen), 64'(0));
        do_start(0, 1, 32'd8, 32'd2);
        expect_done("after_rst", 32'h00000004, 1'b0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
